ixu_wb_arbiter: RTL and testbench
=================================

IXU_WB_ARBITER -- requirements
Module: ixu_wb_arbiter

Interface
REQ-001 SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: lane_wr_en  input  3  per-lane writeback valid; bit k is IXU lane k.
REQ-005 SHALL have port: lane_rd  input  15  per-lane destination register, 5 bits per lane, lane k at [5k+4:5k].
REQ-006 SHALL have port: lane_data  input  96  per-lane write data, 32 bits per lane, lane k at [32k+31:32k].
REQ-007 SHALL have port: rf_wr_en  output  1  register-file write enable, registered.
REQ-008 SHALL have port: rf_rd  output  5  register-file write address, registered.
REQ-009 SHALL have port: rf_data  output  32  register-file write data, registered.
REQ-010 SHALL have port: rf_lane  output  2  lane index of the current write, registered.
REQ-011 SHALL have port: stall  output  1  pipeline stall to all IXU lanes.
REQ-012 SHALL have port: perf_stall_cnt  output  16  stall-cycle counter.
REQ-013 SHALL have port: perf_wr_conflict_cnt  output  16  same-rd conflict counter.

Function
REQ-014 SHALL own one holding register per lane: valid, rd, data.
REQ-015 SHALL drive stall combinationally as the OR of the three holding-register valid bits.
REQ-016 SHALL sample lane inputs only in cycles where stall=0 and ignore them in cycles where stall=1.
REQ-017 SHALL treat a lane request as eligible when it is sampled, lane_wr_en[k]=1, and rd!=0; rd=0 requests are dropped without a grant.
REQ-018 SHALL, when two or more eligible lanes target the same rd in one sample, keep only the highest-numbered lane and increment perf_wr_conflict_cnt once per sample with a conflict.
REQ-019 SHALL keep a 2-bit round-robin pointer rr_ptr in the range 0..2; the priority order is rr_ptr, rr_ptr+1, rr_ptr+2 mod 3.
REQ-020 SHALL, in a cycle with stall=0, grant the first surviving eligible lane in rr order and load every other surviving lane into its holding register.
REQ-021 SHALL, in a cycle with stall=1, grant the first valid holding register in rr order and clear it in the same edge.
REQ-022 SHALL, on a grant to lane k, set rr_ptr=(k+1) mod 3 at the next edge; with no grant, rr_ptr holds.
REQ-023 SHALL register the granted rd, data and lane to rf_rd, rf_data and rf_lane, with rf_wr_en=1, one cycle after the grant (latency 1); with no grant, rf_wr_en=0 and the other outputs hold.
REQ-024 SHALL bound the stall length to at most 2 cycles per sampled bundle; stall drops in the cycle after the last holding register drains.
REQ-025 SHALL increment perf_stall_cnt in every cycle with stall=1; both counters saturate at 16'hFFFF.

Reset
REQ-026 SHALL, while rst=1, clear all holding valids, set rr_ptr=0, rf_wr_en=0, rf_rd=0, rf_data=0, rf_lane=0, and both counters to 0; stall therefore reads 0 in the cycle after reset.
REQ-027 SHALL discard held entries when reset occurs mid-drain, with no write issued for them.

Configuration
REQ-028 SHALL compile the perf counters only when macro IXU_WB_ARB_PERF_EN is defined; without it, both counter ports exist, are driven constant 0, and no counter flops are built.

Verification
REQ-029 SHALL cover single write: lane1 wr rd=5 data=0xAAAA0001 -> next cycle rf_wr_en=1, rf_rd=5, rf_lane=1, stall=0 throughout, rr_ptr=2.
REQ-030 SHALL cover full bundle: after reset, lanes0/1/2 write rd=1/2/3 in one cycle -> stall=1 for 2 cycles; writes to rd 1, 2, 3 appear on consecutive cycles; inputs changed during stall are ignored.
REQ-031 SHALL cover same-rd conflict: lanes0 and 2 write rd=7 with data 0x11 and 0x22 -> exactly one write of rd=7 data=0x22, no stall, perf_wr_conflict_cnt=1.
REQ-032 SHALL cover x0 drop: all lanes write rd=0 -> no rf_wr_en pulse and stall stays 0.
REQ-033 SHALL cover reset mid-drain: full bundle, then rst=1 on the first stall cycle -> no further writes, stall=0, and counters=0 after reset.
REQ-034 SHALL cover the build without IXU_WB_ARB_PERF_EN: repeat the full-bundle scenario -> identical writes and both counter ports read 0.

Source files
------------

// File: rtl/ixu_wb_arbiter.sv
// Three-lane IXU writeback arbiter onto a single register-file write port.
// Perf counters are built only when IXU_WB_ARB_PERF_EN is defined.
module ixu_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  lane_wr_en,
   input  logic [14:0] lane_rd,
   input  logic [95:0] lane_data,
   output logic        rf_wr_en,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_data,
   output logic [1:0]  rf_lane,
   output logic        stall,
   output logic [15:0] perf_stall_cnt,
   output logic [15:0] perf_wr_conflict_cnt
);

   logic [2:0]  hold_valid;
   logic [4:0]  hold_rd   [3];
   logic [31:0] hold_data [3];
   logic [1:0]  rr_ptr;

   logic [4:0]  in_rd   [3];
   logic [31:0] in_data [3];
   logic [2:0]  elig;
   logic [2:0]  survive;
   logic [2:0]  cand;
   logic [1:0]  o0, o1, o2;
   logic        gnt_valid;
   logic [1:0]  gnt_lane;
   logic [2:0]  gnt_onehot;
   logic [4:0]  gnt_rd;
   logic [31:0] gnt_data;

   assign stall = |hold_valid;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         in_rd[k]   = lane_rd[5*k +: 5];
         in_data[k] = lane_data[32*k +: 32];
         elig[k]    = lane_wr_en[k] && (lane_rd[5*k +: 5] != 5'd0);
      end
   end

   // Same-rd collisions resolve toward the highest-numbered lane.
   always_comb begin
      survive[2] = elig[2];
      survive[1] = elig[1] && !(elig[2] && (in_rd[2] == in_rd[1]));
      survive[0] = elig[0] && !(elig[1] && (in_rd[1] == in_rd[0]))
                           && !(elig[2] && (in_rd[2] == in_rd[0]));
   end

   always_comb begin
      cand = stall ? hold_valid : survive;
      case (rr_ptr)
         2'd1:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
         2'd2:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
         default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
      endcase
      gnt_valid = 1'b1;
      gnt_lane  = o0;
      if (cand[o0])      gnt_lane = o0;
      else if (cand[o1]) gnt_lane = o1;
      else if (cand[o2]) gnt_lane = o2;
      else               gnt_valid = 1'b0;
      gnt_onehot = gnt_valid ? (3'b001 << gnt_lane) : 3'b000;
      gnt_rd     = stall ? hold_rd[gnt_lane]   : in_rd[gnt_lane];
      gnt_data   = stall ? hold_data[gnt_lane] : in_data[gnt_lane];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 3'b000;
         rr_ptr     <= 2'd0;
         rf_wr_en   <= 1'b0;
         rf_rd      <= 5'd0;
         rf_data    <= 32'd0;
         rf_lane    <= 2'd0;
      end else begin
         if (stall) hold_valid <= hold_valid & ~gnt_onehot;
         else       hold_valid <= survive & ~gnt_onehot;
         rf_wr_en <= gnt_valid;
         if (gnt_valid) begin
            rf_rd   <= gnt_rd;
            rf_data <= gnt_data;
            rf_lane <= gnt_lane;
            rr_ptr  <= (gnt_lane == 2'd2) ? 2'd0 : gnt_lane + 2'd1;
         end
      end
   end

   // Payload needs no reset; the valid bits alone qualify it.
   always_ff @(posedge clk) begin
      if (!stall) begin
         for (int k = 0; k < 3; k++) begin
            hold_rd[k]   <= in_rd[k];
            hold_data[k] <= in_data[k];
         end
      end
   end

`ifdef IXU_WB_ARB_PERF_EN
   logic        conflict;
   logic [15:0] stall_cnt_q;
   logic [15:0] conflict_cnt_q;

   assign conflict = |(elig & ~survive);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q    <= 16'd0;
         conflict_cnt_q <= 16'd0;
      end else begin
         if (stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
         if (!stall && conflict && (conflict_cnt_q != 16'hFFFF))
            conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end
   end

   assign perf_stall_cnt       = stall_cnt_q;
   assign perf_wr_conflict_cnt = conflict_cnt_q;
`else
   assign perf_stall_cnt       = 16'd0;
   assign perf_wr_conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ixu_wb_arbiter.sv
// Self-checking bench for ixu_wb_arbiter: scenario tasks plus a write scoreboard.
module tb_ixu_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  lane_wr_en;
   logic [14:0] lane_rd;
   logic [95:0] lane_data;
   logic        rf_wr_en;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;
   logic [1:0]  rf_lane;
   logic        stall;
   logic [15:0] perf_stall_cnt;
   logic [15:0] perf_wr_conflict_cnt;

`ifdef IXU_WB_ARB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [1:0]  lane;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   ixu_wb_arbiter dut (
      .clk(clk), .rst(rst), .lane_wr_en(lane_wr_en), .lane_rd(lane_rd),
      .lane_data(lane_data), .rf_wr_en(rf_wr_en), .rf_rd(rf_rd),
      .rf_data(rf_data), .rf_lane(rf_lane), .stall(stall),
      .perf_stall_cnt(perf_stall_cnt), .perf_wr_conflict_cnt(perf_wr_conflict_cnt)
   );

   always #5 clk = ~clk;

   // Scoreboard: every write the DUT issues must match the oldest expected one.
   always @(negedge clk) begin
      wr_t e;
      if (rf_wr_en === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_write: got rd=%0d data=%h lane=%0d, expected no write",
                     rf_rd, rf_data, rf_lane);
         end else begin
            e = exp_q.pop_front();
            if ({rf_rd, rf_data, rf_lane} !== e) begin
               n_errors++;
               $display("FAIL write_content: got rd=%0d data=%h lane=%0d, expected rd=%0d data=%h lane=%0d",
                        rf_rd, rf_data, rf_lane, e.rd, e.data, e.lane);
            end
         end
      end
   end

   task automatic drive(input logic [2:0] en, input logic [4:0] r0, r1, r2,
                        input logic [31:0] d0, d1, d2);
      lane_wr_en = en;
      lane_rd    = {r2, r1, r0};
      lane_data  = {d2, d1, d0};
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic [1:0] lane);
      wr_t e;
      e.rd = rd; e.data = data; e.lane = lane;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      n_checks++;
      if ({rf_wr_en, rf_rd, rf_data, rf_lane} !== 40'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got en=%b rd=%0d data=%h lane=%0d, expected all 0",
                  rf_wr_en, rf_rd, rf_data, rf_lane);
      end
      n_checks++;
      if (stall !== 1'b0) begin
         n_errors++; $display("FAIL reset_stall: got %b, expected 0", stall);
      end
      n_checks++;
      if ({perf_stall_cnt, perf_wr_conflict_cnt} !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_counters: got %0d/%0d, expected 0/0", perf_stall_cnt, perf_wr_conflict_cnt);
      end
   endtask

   task automatic test_single_write();
      @(posedge clk); #1;
      drive(3'b010, 5'd0, 5'd5, 5'd0, 32'd0, 32'hAAAA0001, 32'd0);
      push(5'd5, 32'hAAAA0001, 2'd1);
      @(posedge clk); #1;
      drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      n_checks++;
      if (rf_wr_en !== 1'b1 || stall !== 1'b0) begin
         n_errors++;
         $display("FAIL single_write: got en=%b stall=%b, expected en=1 stall=0", rf_wr_en, stall);
      end
      n_checks++;
      if (dut.rr_ptr !== 2'd2) begin
         n_errors++; $display("FAIL single_rr_ptr: got %0d, expected 2", dut.rr_ptr);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rf_wr_en !== 1'b0 || stall !== 1'b0) begin
         n_errors++;
         $display("FAIL single_idle: got en=%b stall=%b, expected en=0 stall=0", rf_wr_en, stall);
      end
   endtask

   task automatic test_full_bundle();
      logic [4:0]  exp_rd   [3];
      logic [1:0]  exp_lane [3];
      logic        exp_stall[3];
      exp_rd    = '{5'd1, 5'd2, 5'd3};
      exp_lane  = '{2'd0, 2'd1, 2'd2};
      exp_stall = '{1'b1, 1'b1, 1'b0};
      do_reset();
      drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0000001, 32'hA0000002, 32'hA0000003);
      push(5'd1, 32'hA0000001, 2'd0);
      push(5'd2, 32'hA0000002, 2'd1);
      push(5'd3, 32'hA0000003, 2'd2);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         // Garbage during the stall must be ignored; cleared before stall drops.
         if (i == 0) drive(3'b111, 5'd9, 5'd10, 5'd11, 32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002);
         else        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
         n_checks++;
         if (stall !== exp_stall[i] || rf_wr_en !== 1'b1 || rf_rd !== exp_rd[i] || rf_lane !== exp_lane[i]) begin
            n_errors++;
            $display("FAIL bundle_cycle%0d: got stall=%b en=%b rd=%0d lane=%0d, expected stall=%b en=1 rd=%0d lane=%0d",
                     i, stall, rf_wr_en, rf_rd, rf_lane, exp_stall[i], exp_rd[i], exp_lane[i]);
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (rf_wr_en !== 1'b0 || stall !== 1'b0) begin
         n_errors++;
         $display("FAIL bundle_after: got en=%b stall=%b, expected en=0 stall=0", rf_wr_en, stall);
      end
      n_checks++;
      if (perf_stall_cnt !== (PERF ? 16'd2 : 16'd0) || perf_wr_conflict_cnt !== 16'd0) begin
         n_errors++;
         $display("FAIL bundle_counters: got stall_cnt=%0d conflict_cnt=%0d, expected %0d/0",
                  perf_stall_cnt, perf_wr_conflict_cnt, PERF ? 2 : 0);
      end
   endtask

   task automatic test_conflict();
      do_reset();
      drive(3'b101, 5'd7, 5'd0, 5'd7, 32'h11, 32'd0, 32'h22);
      push(5'd7, 32'h22, 2'd2);
      @(posedge clk); #1;
      drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      n_checks++;
      if (stall !== 1'b0 || rf_wr_en !== 1'b1 || rf_data !== 32'h22) begin
         n_errors++;
         $display("FAIL conflict_write: got stall=%b en=%b data=%h, expected stall=0 en=1 data=22",
                  stall, rf_wr_en, rf_data);
      end
      n_checks++;
      if (perf_wr_conflict_cnt !== (PERF ? 16'd1 : 16'd0)) begin
         n_errors++;
         $display("FAIL conflict_cnt: got %0d, expected %0d", perf_wr_conflict_cnt, PERF ? 1 : 0);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rf_wr_en !== 1'b0 || stall !== 1'b0) begin
         n_errors++;
         $display("FAIL conflict_single: got en=%b stall=%b, expected en=0 stall=0", rf_wr_en, stall);
      end
   endtask

   task automatic test_x0_drop();
      drive(3'b111, 5'd0, 5'd0, 5'd0, 32'h1, 32'h2, 32'h3);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (rf_wr_en !== 1'b0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL x0_drop%0d: got en=%b stall=%b, expected en=0 stall=0", i, rf_wr_en, stall);
         end
      end
      drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hB0000001, 32'hB0000002, 32'hB0000003);
      push(5'd1, 32'hB0000001, 2'd0);
      @(posedge clk); #1;
      n_checks++;
      if (stall !== 1'b1) begin
         n_errors++; $display("FAIL middrain_stall: got %b, expected 1", stall);
      end
      rst = 1'b1;
      drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if (stall !== 1'b0 || rf_wr_en !== 1'b0 || rf_rd !== 5'd0 ||
          perf_stall_cnt !== 16'd0 || perf_wr_conflict_cnt !== 16'd0) begin
         n_errors++;
         $display("FAIL middrain_reset: got stall=%b en=%b rd=%0d cnt=%0d/%0d, expected 0 0 0 0/0",
                  stall, rf_wr_en, rf_rd, perf_stall_cnt, perf_wr_conflict_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (rf_wr_en !== 1'b0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL middrain_quiet%0d: got en=%b stall=%b, expected en=0 stall=0", i, rf_wr_en, stall);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_full_bundle();
      test_conflict();
      test_x0_drop();
      test_reset_mid_drain();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL missing_writes: got %0d writes still pending, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
